pc_fetch_sequencer: RTL and testbench

Sequences the program counter register and the instruction-memory fetch for the single-issue LEG core. It drives the PC register's select and load inputs, runs a req/ack fetch handshake with instruction memory, and presents fetched instructions to decode with a valid/ready handshake. It also absorbs branch redirects from execute, including redirects that arrive mid-fetch, and handles halt.

---
 rtl/pc_fetch_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_pc_fetch_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer: drives the PC register and the instruction-memory fetch
// for the single-issue LEG core. It steers branch redirects from execute,
// including ones that arrive while a fetch is outstanding, and handles halt.
//
// Handshakes:
//   imem_req/imem_ack: imem_req is held high until the cycle in which imem_ack
//   is seen. imem_rdata is taken only in that cycle. imem_ack is ignored unless
//   the FSM is in FETCH with imem_req high.
//   instr_valid/instr_ready: a transfer completes on any cycle with both high.
//   instr and instr_pc do not change while instr_valid is high and instr_ready
//   is low. instr_valid is withdrawn early only when a branch redirect lands.
module pc_fetch_sequencer #(
  parameter int RESET_DELAY = 2,
  parameter int COUNT_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  output logic [1:0]         pc_sel,
  output logic [31:0]        pc_in,
  input  logic [31:0]        pc_out,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ack,
  input  logic [31:0]        imem_rdata,
  output logic               instr_valid,
  output logic [31:0]        instr,
  output logic [31:0]        instr_pc,
  input  logic               instr_ready,
  input  logic               br_valid,
  input  logic               br_rel,
  input  logic [31:0]        br_target,
  input  logic               halt,
  output logic               halted,
  output logic [COUNT_W-1:0] fetch_count,
  output logic [1:0]         o_dbg_state
);

  localparam int BOOT_W = (RESET_DELAY > 0) ? $clog2(RESET_DELAY + 1) : 1;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t              r_state;
  logic [BOOT_W-1:0]   r_boot_cnt;
  logic                r_pend_valid;
  logic                r_pend_rel;
  logic [31:0]         r_pend_target;
  logic                r_imem_req;
  logic                r_instr_valid;
  logic [31:0]         r_instr;
  logic [31:0]         r_instr_pc;
  logic                r_halted;
  logic [COUNT_W-1:0]  r_count;

  logic                w_ack;
  logic                w_redirect;
  logic [1:0]          w_pc_sel;
  logic [31:0]         w_pc_in;

  // An ack only counts while a request is actually outstanding; during the
  // one-cycle bubble after a redirect the request is low and ack is ignored.
  assign w_ack      = (r_state == S_FETCH) && r_imem_req && imem_ack;
  assign w_redirect = br_valid || r_pend_valid;

  // PC register steering; the PC register acts on these at the same edge.
  always_comb begin
    w_pc_sel = 2'd0;
    w_pc_in  = 32'd0;
    case (r_state)
      S_FETCH: begin
        if (w_ack) begin
          if (br_valid) begin
            w_pc_sel = br_rel ? 2'd3 : 2'd2;
            w_pc_in  = br_target;
          end else if (r_pend_valid) begin
            w_pc_sel = r_pend_rel ? 2'd3 : 2'd2;
            w_pc_in  = r_pend_target;
          end else begin
            w_pc_sel = 2'd1;
          end
        end
      end
      S_HOLD: begin
        if (br_valid) begin
          w_pc_sel = br_rel ? 2'd3 : 2'd2;
          w_pc_in  = br_target;
        end
      end
      default: begin
        w_pc_sel = 2'd0;
        w_pc_in  = 32'd0;
      end
    endcase
  end

  // Sequencer FSM with registered request, decode-side outputs and counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_BOOT;
      r_boot_cnt    <= BOOT_W'(RESET_DELAY);
      r_pend_valid  <= 1'b0;
      r_pend_rel    <= 1'b0;
      r_pend_target <= 32'd0;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instr       <= 32'd0;
      r_instr_pc    <= 32'd0;
      r_halted      <= 1'b0;
      r_count       <= '0;
    end else begin
      case (r_state)
        S_BOOT: begin
          if (r_boot_cnt == '0) begin
            if (halt) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end else begin
              r_state    <= S_FETCH;
              r_imem_req <= 1'b1;
            end
          end else begin
            r_boot_cnt <= r_boot_cnt - BOOT_W'(1);
          end
        end
        S_FETCH: begin
          if (w_ack) begin
            r_imem_req <= 1'b0;
            if (w_redirect) begin
              // Fetched word belongs to the wrong path; drop it.
              r_pend_valid <= 1'b0;
              if (halt) begin
                r_state  <= S_HALT;
                r_halted <= 1'b1;
              end
            end else begin
              r_instr       <= imem_rdata;
              r_instr_pc    <= pc_out;
              r_instr_valid <= 1'b1;
              r_state       <= S_HOLD;
            end
          end else begin
            if (br_valid) begin
              r_pend_valid  <= 1'b1;
              r_pend_rel    <= br_rel;
              r_pend_target <= br_target;
            end
            // End of the post-redirect bubble: request the new PC.
            r_imem_req <= 1'b1;
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            r_count <= r_count + COUNT_W'(1);
          end
          if (br_valid || instr_ready) begin
            r_instr_valid <= 1'b0;
            if (halt) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end else begin
              r_state    <= S_FETCH;
              r_imem_req <= 1'b1;
            end
          end
        end
        default: begin
          r_state       <= S_HALT;
          r_halted      <= 1'b1;
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign pc_sel      = w_pc_sel;
  assign pc_in       = w_pc_in;
  assign imem_req    = r_imem_req;
  assign imem_addr   = pc_out;
  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign halted      = r_halted;
  assign fetch_count = r_count;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Testbench for pc_fetch_sequencer: a behavioural PC register model, a
// per-cycle vector table with hand-computed expectations, and hand-written
// halt / reset sequences.
module tb_pc_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic [1:0]  pc_sel;
  logic [31:0] pc_in;
  logic [31:0] pc_out;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        br_valid;
  logic        br_rel;
  logic [31:0] br_target;
  logic        halt;
  logic        halted;
  logic [31:0] fetch_count;
  logic [1:0]  dbg_state;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        rdy;
    logic        bv;
    logic        brel;
    logic [31:0] btgt;
    logic        hlt;
    logic [1:0]  sel;
    logic [31:0] pin;
    logic        req;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] ipc;
    logic [31:0] ins;
    logic [31:0] cnt;
    logic        hd;
  } vec_t;

  vec_t vecs[$];

  pc_fetch_sequencer #(.RESET_DELAY(2), .COUNT_W(32)) dut (
    .clk(clk), .rst(rst), .pc_sel(pc_sel), .pc_in(pc_in), .pc_out(pc_out),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .instr_ready(instr_ready), .br_valid(br_valid),
    .br_rel(br_rel), .br_target(br_target), .halt(halt), .halted(halted),
    .fetch_count(fetch_count), .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register model: acts on pc_sel/pc_in at the rising edge.
  always @(posedge clk or posedge rst) begin
    if (rst) pc_out <= 32'd0;
    else begin
      case (pc_sel)
        2'd1:    pc_out <= pc_out + 32'd4;
        2'd2:    pc_out <= pc_in;
        2'd3:    pc_out <= pc_out + (pc_in << 2) + 32'd4;
        default: pc_out <= pc_out;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic ack, input logic [31:0] rdata, input logic rdy,
                     input logic bv, input logic brel, input logic [31:0] btgt,
                     input logic hlt, input logic [1:0] sel, input logic [31:0] pin,
                     input logic req, input logic [31:0] addr, input logic iv,
                     input logic [31:0] ipc, input logic [31:0] ins,
                     input logic [31:0] cnt, input logic hd);
    vec_t v;
    v.ack = ack; v.rdata = rdata; v.rdy = rdy; v.bv = bv; v.brel = brel;
    v.btgt = btgt; v.hlt = hlt; v.sel = sel; v.pin = pin; v.req = req;
    v.addr = addr; v.iv = iv; v.ipc = ipc; v.ins = ins; v.cnt = cnt; v.hd = hd;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic ack, input logic [31:0] rdata, input logic rdy,
                       input logic bv, input logic brel, input logic [31:0] btgt,
                       input logic hlt);
    imem_ack = ack; imem_rdata = rdata; instr_ready = rdy;
    br_valid = bv; br_rel = brel; br_target = btgt; halt = hlt;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pc_sel"}, 32'(pc_sel), 32'd0);
    chk({tag, "_pc_in"}, pc_in, 32'd0);
    chk({tag, "_imem_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_instr"}, instr, 32'd0);
    chk({tag, "_instr_pc"}, instr_pc, 32'd0);
    chk({tag, "_halted"}, 32'(halted), 32'd0);
    chk({tag, "_fetch_count"}, fetch_count, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

    // Cycle k = the clock period after rising edge k following reset release.
    //   ack rdata         rdy bv rl btgt          h | sel pin           req addr      iv ipc     ins           cnt hd
    // boot: two idle cycles, first request in cycle 3, ack one cycle later
    add(0, 32'h0,         1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,   0, 32'h0,   32'h0,        0, 0);
    add(0, 32'h0,         1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,   0, 32'h0,   32'h0,        0, 0);
    add(0, 32'h0,         1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,   0, 32'h0,   32'h0,        0, 0);
    add(0, 32'h0,         1, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h0,   0, 32'h0,   32'h0,        0, 0);
    add(1, 32'h1000_0000, 1, 0, 0, 32'h0,        0, 1, 32'h0,        1, 32'h0,   0, 32'h0,   32'h0,        0, 0);
    add(0, 32'h0,         1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h4,   1, 32'h0,   32'h1000_0000, 0, 0);
    add(0, 32'h0,         1, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h4,   0, 32'h0,   32'h0,        1, 0);
    add(1, 32'h1000_0004, 1, 0, 0, 32'h0,        0, 1, 32'h0,        1, 32'h4,   0, 32'h0,   32'h0,        1, 0);
    add(0, 32'h0,         1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h8,   1, 32'h4,   32'h1000_0004, 1, 0);
    add(0, 32'h0,         1, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h8,   0, 32'h0,   32'h0,        2, 0);
    add(1, 32'h1000_0008, 1, 0, 0, 32'h0,        0, 1, 32'h0,        1, 32'h8,   0, 32'h0,   32'h0,        2, 0);
    add(0, 32'h0,         1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'hC,   1, 32'h8,   32'h1000_0008, 2, 0);
    // slow memory (ack after 3 waiting cycles) and decode stalling 2 cycles
    add(0, 32'h0,         0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'hC,   0, 32'h0,   32'h0,        3, 0);
    add(0, 32'h0,         0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'hC,   0, 32'h0,   32'h0,        3, 0);
    add(0, 32'h0,         0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'hC,   0, 32'h0,   32'h0,        3, 0);
    add(1, 32'hDEAD_BEEF, 0, 0, 0, 32'h0,        0, 1, 32'h0,        1, 32'hC,   0, 32'h0,   32'h0,        3, 0);
    add(0, 32'h0,         0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h10,  1, 32'hC,   32'hDEAD_BEEF, 3, 0);
    add(0, 32'h0,         0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h10,  1, 32'hC,   32'hDEAD_BEEF, 3, 0);
    add(0, 32'h0,         1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h10,  1, 32'hC,   32'hDEAD_BEEF, 3, 0);
    // absolute redirect while fetching 0x10: word dropped, bubble, refetch 0x100
    add(0, 32'h0,         1, 1, 0, 32'h100,      0, 0, 32'h0,        1, 32'h10,  0, 32'h0,   32'h0,        4, 0);
    add(1, 32'h1111_1111, 1, 0, 0, 32'h0,        0, 2, 32'h100,      1, 32'h10,  0, 32'h0,   32'h0,        4, 0);
    add(0, 32'h0,         1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h100, 0, 32'h0,   32'h0,        4, 0);
    // two pending redirects then a live one on the ack cycle: live wins
    add(0, 32'h0,         1, 1, 0, 32'h200,      0, 0, 32'h0,        1, 32'h100, 0, 32'h0,   32'h0,        4, 0);
    add(0, 32'h0,         1, 1, 1, 32'h5,        0, 0, 32'h0,        1, 32'h100, 0, 32'h0,   32'h0,        4, 0);
    add(1, 32'h2222_2222, 1, 1, 0, 32'h300,      0, 2, 32'h300,      1, 32'h100, 0, 32'h0,   32'h0,        4, 0);
    add(0, 32'h0,         1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h300, 0, 32'h0,   32'h0,        4, 0);
    add(0, 32'h0,         1, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h300, 0, 32'h0,   32'h0,        4, 0);
    // pending cleared: next ack is a plain PC+4
    add(1, 32'h3333_3333, 1, 0, 0, 32'h0,        0, 1, 32'h0,        1, 32'h300, 0, 32'h0,   32'h0,        4, 0);
    // relative redirect -2 from HOLD with ready: counts, refetches 0x304-8+4
    add(0, 32'h0,         1, 1, 1, 32'hFFFF_FFFE, 0, 3, 32'hFFFF_FFFE, 0, 32'h304, 1, 32'h300, 32'h3333_3333, 4, 0);
    // halt raised during a fetch: fetch and delivery complete, then HALT
    add(0, 32'h0,         1, 0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h300, 0, 32'h0,   32'h0,        5, 0);
    add(1, 32'h4444_4444, 1, 0, 0, 32'h0,        1, 1, 32'h0,        1, 32'h300, 0, 32'h0,   32'h0,        5, 0);
    add(0, 32'h0,         1, 0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h304, 1, 32'h300, 32'h4444_4444, 5, 0);
    // in HALT: branches and ack ignored
    add(1, 32'h0,         1, 1, 0, 32'h500,      0, 0, 32'h0,        0, 32'h304, 0, 32'h0,   32'h0,        6, 1);
    add(0, 32'h0,         1, 1, 1, 32'h1,        1, 0, 32'h0,        0, 32'h304, 0, 32'h0,   32'h0,        6, 1);

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // driver: apply one vector per cycle, compare before the next edge
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ack, vecs[i].rdata, vecs[i].rdy, vecs[i].bv, vecs[i].brel,
            vecs[i].btgt, vecs[i].hlt);
      #1;
      chk($sformatf("c%0d_pc_sel", i), 32'(pc_sel), 32'(vecs[i].sel));
      chk($sformatf("c%0d_pc_in", i), pc_in, vecs[i].pin);
      chk($sformatf("c%0d_imem_req", i), 32'(imem_req), 32'(vecs[i].req));
      chk($sformatf("c%0d_imem_addr", i), imem_addr, vecs[i].addr);
      chk($sformatf("c%0d_instr_valid", i), 32'(instr_valid), 32'(vecs[i].iv));
      if (vecs[i].iv) begin
        chk($sformatf("c%0d_instr_pc", i), instr_pc, vecs[i].ipc);
        chk($sformatf("c%0d_instr", i), instr, vecs[i].ins);
      end
      chk($sformatf("c%0d_fetch_count", i), fetch_count, vecs[i].cnt);
      chk($sformatf("c%0d_halted", i), 32'(halted), 32'(vecs[i].hd));
      @(negedge clk);
    end

    // asynchronous reset in HALT clears outputs without waiting for an edge
    rst = 1'b1;
    #1;
    chk_all_zero("rst_in_halt");

    // ack during BOOT is ignored; first request after two idle cycles
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive((k < 3) || (k == 4), 32'h5555_0000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      #1;
      chk($sformatf("boot%0d_imem_req", k), 32'(imem_req), (k >= 3) ? 32'd1 : 32'd0);
      chk($sformatf("boot%0d_pc_sel", k), 32'(pc_sel), (k == 4) ? 32'd1 : 32'd0);
      chk($sformatf("boot%0d_instr_valid", k), 32'(instr_valid), 32'd0);
      @(negedge clk);
    end
    #1;
    chk("boot_instr_valid_after_ack", 32'(instr_valid), 32'd1);
    chk("boot_instr", instr, 32'h5555_0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
